debounce_bank: RTL and testbench

- Multi-channel input debouncer/qualifier for discrete command and status inputs. It is the successor to the fixed-width per-bit filter bank.
- Adds an input synchroniser and runtime rise/fall thresholds.
- Offers two filter modes: consecutive-count, or up/down integrator with hysteresis.
- Adds a per-channel enable and registered edge-event strobes.
- Sits between the raw input pins and the command decoding logic.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 118 +++++++++++
 rtl/debounce_bank.sv | 60 ++++++
 tb/tb_debounce_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce bank.
//   db_mode_e : filter mode selector (consecutive-count or integrator)
//   cnt_max   : largest value a counter of the given width can hold
//   clamp_th  : maps a zero threshold to one for the consecutive-count filter
package debounce_pkg;

    typedef enum logic {
        DB_CONSEC = 1'b0,
        DB_INTEG  = 1'b1
    } db_mode_e;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic int unsigned clamp_th(input int unsigned th);
        return (th == 32'd0) ? 32'd1 : th;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: input synchroniser, filter counter, filtered
// level and registered edge strobes.
// Ports:
//   clk      - clock
//   sclr_n   - synchronous reset, active low
//   din      - raw input pin
//   en       - channel enable; low freezes counter and level
//   th_rise  - rise threshold
//   th_fall  - fall threshold
//   dout     - filtered level
//   rise     - one-cycle strobe on dout 0->1
//   fall     - one-cycle strobe on dout 1->0
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int       CNT_WIDTH   = 4,
    parameter db_mode_e MODE        = DB_CONSEC,
    parameter int       SYNC_STAGES = 2,
    parameter logic     INIT_VALUE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 sclr_n,
    input  logic                 din,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] th_rise,
    input  logic [CNT_WIDTH-1:0] th_fall,
    output logic                 dout,
    output logic                 rise,
    output logic                 fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(cnt_max(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    // An integrator that comes out of reset high must start full, otherwise
    // the first cycle would immediately satisfy the fall condition.
    localparam logic [CNT_WIDTH-1:0] CNT_RESET =
        ((MODE == DB_INTEG) && INIT_VALUE) ? CNT_MAX : '0;

    logic                 s;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 out_d;
    logic [CNT_WIDTH-1:0] th_sel;
    logic [CNT_WIDTH:0]   th_eff;
    logic [CNT_WIDTH:0]   cnt_inc;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Runs independently of en so a re-enabled channel sees a
            // current sample rather than a stale one.
            always_ff @(posedge clk) begin
                if (!sclr_n) begin
                    sync_q <= {SYNC_STAGES{INIT_VALUE}};
                end else begin
                    sync_q[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        th_sel  = s ? th_rise : th_fall;
        th_eff  = (CNT_WIDTH+1)'(clamp_th(32'(th_sel)));
        // One bit wider so the compare cannot wrap if the threshold was
        // lowered below the held count.
        cnt_inc = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        out_d   = dout;
        if (MODE == DB_CONSEC) begin
            if (s == dout) begin
                cnt_d = '0;
            end else if (cnt_inc >= th_eff) begin
                out_d = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc[CNT_WIDTH-1:0];
            end
        end else begin
            if (s) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
            end
            if (!dout && (cnt_d >= th_rise)) begin
                out_d = 1'b1;
            end else if (dout && (cnt_d <= th_fall)) begin
                out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            cnt_q <= CNT_RESET;
            dout  <= INIT_VALUE;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else if (en) begin
            cnt_q <= cnt_d;
            dout  <= out_d;
            rise  <= out_d & ~dout;
            fall  <= ~out_d & dout;
        end else begin
            rise  <= 1'b0;
            fall  <= 1'b0;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer/qualifier between raw input pins and command
// decoding. Each channel is an independent debounce_ch.
// Ports:
//   clk        - clock
//   sclr_n     - synchronous reset, active low
//   in         - raw inputs, one per channel
//   en         - per-channel enable
//   th_rise    - rise threshold shared by all channels
//   th_fall    - fall threshold shared by all channels
//   out        - filtered levels
//   rise       - one-cycle strobes on out 0->1
//   fall       - one-cycle strobes on out 1->0
//   any_change - OR of every rise and fall strobe
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   NUM_SIGNALS = 16,
    parameter int   CNT_WIDTH   = 4,
    parameter int   MODE        = 0,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_VALUE  = 1'b0
) (
    input  logic                   clk,
    input  logic                   sclr_n,
    input  logic [NUM_SIGNALS-1:0] in,
    input  logic [NUM_SIGNALS-1:0] en,
    input  logic [CNT_WIDTH-1:0]   th_rise,
    input  logic [CNT_WIDTH-1:0]   th_fall,
    output logic [NUM_SIGNALS-1:0] out,
    output logic [NUM_SIGNALS-1:0] rise,
    output logic [NUM_SIGNALS-1:0] fall,
    output logic                   any_change
);

    localparam db_mode_e MODE_E = (MODE == 1) ? DB_INTEG : DB_CONSEC;

    generate
        for (genvar i = 0; i < NUM_SIGNALS; i++) begin : g_ch
            debounce_ch #(
                .CNT_WIDTH   (CNT_WIDTH),
                .MODE        (MODE_E),
                .SYNC_STAGES (SYNC_STAGES),
                .INIT_VALUE  (INIT_VALUE)
            ) u_ch (
                .clk     (clk),
                .sclr_n  (sclr_n),
                .din     (in[i]),
                .en      (en[i]),
                .th_rise (th_rise),
                .th_fall (th_fall),
                .dout    (out[i]),
                .rise    (rise[i]),
                .fall    (fall[i])
            );
        end
    endgenerate

    assign any_change = |{rise, fall};

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    typedef struct {
        string       tag;
        int          dut;
        logic        rst_n;
        logic [15:0] in_v;
        logic [15:0] en_v;
        logic [3:0]  thr;
        logic [3:0]  thf;
        logic [15:0] exp_out;
        logic [15:0] exp_rise;
        logic [15:0] exp_fall;
    } vec_t;

    typedef struct {
        string       tag;
        int          dut;
        logic [15:0] o;
        logic [15:0] r;
        logic [15:0] f;
        logic        a;
    } exp_t;

    logic        clk = 1'b0;
    logic        sclr_n;
    logic [15:0] en;
    logic [3:0]  th_rise;
    logic [3:0]  th_fall;
    logic [15:0] in0, in1, in2;
    logic [15:0] out0, out1, out2;
    logic [15:0] rise0, rise1, rise2;
    logic [15:0] fall0, fall1, fall2;
    logic        any0, any1, any2;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic        c_rst;
    logic [15:0] c_en;
    logic [3:0]  c_thr, c_thf;
    int          c_dut;

    always #5 clk = ~clk;

    // Consecutive-count, reset low
    debounce_bank #(.NUM_SIGNALS(16), .CNT_WIDTH(4), .MODE(0), .SYNC_STAGES(2), .INIT_VALUE(1'b0)) u_db0 (
        .clk(clk), .sclr_n(sclr_n), .in(in0), .en(en), .th_rise(th_rise), .th_fall(th_fall),
        .out(out0), .rise(rise0), .fall(fall0), .any_change(any0));

    // Consecutive-count, reset high
    debounce_bank #(.NUM_SIGNALS(16), .CNT_WIDTH(4), .MODE(0), .SYNC_STAGES(2), .INIT_VALUE(1'b1)) u_db1 (
        .clk(clk), .sclr_n(sclr_n), .in(in1), .en(en), .th_rise(th_rise), .th_fall(th_fall),
        .out(out1), .rise(rise1), .fall(fall1), .any_change(any1));

    // Integrator, reset low
    debounce_bank #(.NUM_SIGNALS(16), .CNT_WIDTH(4), .MODE(1), .SYNC_STAGES(2), .INIT_VALUE(1'b0)) u_db2 (
        .clk(clk), .sclr_n(sclr_n), .in(in2), .en(en), .th_rise(th_rise), .th_fall(th_fall),
        .out(out2), .rise(rise2), .fall(fall2), .any_change(any2));

    function automatic void addn(input int n, input string tag, input logic [15:0] iv,
                                 input logic [15:0] eo, input logic [15:0] er, input logic [15:0] ef);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.tag = tag; v.dut = c_dut; v.rst_n = c_rst; v.in_v = iv; v.en_v = c_en;
            v.thr = c_thr; v.thf = c_thf; v.exp_out = eo; v.exp_rise = er; v.exp_fall = ef;
            vecs.push_back(v);
        end
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [15:0] ao, ar, af;
        logic        aa;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        case (e.dut)
            0:       begin ao = out0; ar = rise0; af = fall0; aa = any0; end
            1:       begin ao = out1; ar = rise1; af = fall1; aa = any1; end
            default: begin ao = out2; ar = rise2; af = fall2; aa = any2; end
        endcase
        if (ao !== e.o || ar !== e.r || af !== e.f || aa !== e.a) begin
            n_miss++;
            $display("FAIL %s (vec %0d dut%0d): got out=%h rise=%h fall=%h any=%b, want out=%h rise=%h fall=%h any=%b",
                     e.tag, n_vec, e.dut, ao, ar, af, aa, e.o, e.r, e.f, e.a);
        end
    endtask

    // Drives one vector, queues its expectation, and checks after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        sclr_n  = v.rst_n;
        en      = v.en_v;
        th_rise = v.thr;
        th_fall = v.thf;
        case (v.dut)
            0:       in0 = v.in_v;
            1:       in1 = v.in_v;
            default: in2 = v.in_v;
        endcase
        e.tag = v.tag; e.dut = v.dut; e.o = v.exp_out; e.r = v.exp_rise; e.f = v.exp_fall;
        e.a = |{v.exp_rise, v.exp_fall};
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    task automatic hv(input string tag, input logic [15:0] iv,
                      input logic [15:0] eo, input logic [15:0] er, input logic [15:0] ef);
        vec_t v;
        v.tag = tag; v.dut = c_dut; v.rst_n = c_rst; v.in_v = iv; v.en_v = c_en;
        v.thr = c_thr; v.thf = c_thf; v.exp_out = eo; v.exp_rise = er; v.exp_fall = ef;
        apply(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p;
        sclr_n = 1'b0; en = 16'hFFFF; th_rise = 4'd5; th_fall = 4'd5;
        in0 = '0; in1 = '0; in2 = '0;

        // Reset: outputs take INIT_VALUE from the first edge with reset low
        c_rst = 1'b0; c_en = 16'hFFFF; c_thr = 4'd5; c_thf = 4'd5;
        c_dut = 1; addn(1, "rst_u1", 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        c_dut = 0; addn(1, "rst_u0", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        c_dut = 2; addn(1, "rst_u2", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // INIT=1 bank with pins low and th_fall=0: falls after sync+1 edges
        c_dut = 1; c_rst = 1'b1; c_thf = 4'd0;
        addn(2, "thf0_hold",  16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        addn(1, "thf0_fall",  16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        addn(1, "thf0_after", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Consecutive-count rise (th=5 -> 7 edges) and fall (th=3 -> 5 edges)
        c_dut = 0; c_thf = 4'd3;
        addn(6, "m0_wait",  16'h0001, 16'h0000, 16'h0000, 16'h0000);
        addn(1, "m0_rise",  16'h0001, 16'h0001, 16'h0001, 16'h0000);
        addn(1, "m0_hold",  16'h0001, 16'h0001, 16'h0000, 16'h0000);
        addn(4, "m0_fwait", 16'h0000, 16'h0001, 16'h0000, 16'h0000);
        addn(1, "m0_fall",  16'h0000, 16'h0000, 16'h0000, 16'h0001);
        addn(1, "m0_fhold", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // One-sample glitch after count 3 restarts the count
        addn(3, "gl_pre",  16'h0001, 16'h0000, 16'h0000, 16'h0000);
        addn(1, "gl_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addn(6, "gl_wait", 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        addn(1, "gl_rise", 16'h0001, 16'h0001, 16'h0001, 16'h0000);
        addn(1, "gl_hold", 16'h0001, 16'h0001, 16'h0000, 16'h0000);

        // Enable freeze on ch3 after 3 differing samples, th_rise=6
        c_thr = 4'd6;
        addn(5,  "en_pre",    16'h0009, 16'h0001, 16'h0000, 16'h0000);
        c_en = 16'hFFF7;
        addn(10, "en_frozen", 16'h0009, 16'h0001, 16'h0000, 16'h0000);
        c_en = 16'hFFFF;
        addn(2,  "en_resume", 16'h0009, 16'h0001, 16'h0000, 16'h0000);
        addn(1,  "en_rise",   16'h0009, 16'h0009, 16'h0008, 16'h0000);
        addn(1,  "en_hold",   16'h0009, 16'h0009, 16'h0000, 16'h0000);

        // Reset with ch1 at count 4 of 8; 8 fresh samples needed afterwards
        c_thr = 4'd8;
        addn(6, "rm_pre",  16'h000B, 16'h0009, 16'h0000, 16'h0000);
        c_rst = 1'b0;
        addn(1, "rm_rst",  16'h000B, 16'h0000, 16'h0000, 16'h0000);
        c_rst = 1'b1;
        addn(9, "rm_wait", 16'h000B, 16'h0000, 16'h0000, 16'h0000);
        addn(1, "rm_rise", 16'h000B, 16'h000B, 16'h000B, 16'h0000);
        addn(1, "rm_hold", 16'h000B, 16'h000B, 16'h0000, 16'h0000);

        // Integrator, th_rise=10 th_fall=4: 1110 pattern, then 1s, then 0s.
        // Counter sees pattern index k-2; reaches 10 at k=19, drains to 4 at k=52.
        c_dut = 2; c_thr = 4'd10; c_thf = 4'd4;
        for (int k = 0; k <= 60; k++) begin
            if (k < 32)      p = ((k % 4) != 3);
            else if (k < 40) p = 1'b1;
            else             p = 1'b0;
            addn(1, "integ", {15'h0, p}, {15'h0, (k >= 19 && k < 52)},
                 {15'h0, (k == 19)}, {15'h0, (k == 52)});
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Lowering th_fall below a held count toggles on the next differing sample
        c_dut = 0; c_thf = 4'd8;
        for (int i = 0; i < 5; i++) hv("thc_pre", 16'h0009, 16'h000B, 16'h0000, 16'h0000);
        c_thf = 4'd2;
        hv("thc_fall", 16'h0009, 16'h0009, 16'h0000, 16'h0002);
        hv("thc_hold", 16'h0009, 16'h0009, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
